result_collector: RTL and testbench
===================================

Name: result_collector

Overview:
- Output-side counterpart of the systolic array frame: the frame's input skewer staggers data in, and this block de-skews the staggered result columns back into aligned rows.
- Buffers aligned rows in a small FIFO and presents them to a downstream consumer over valid/ready.
- Generates the frame's `output_ready` from buffer occupancy, so the frame only runs when a full matrix of results can be stored.

Parameters:
- MATRIX_SIZE, 2, array dimension N: columns per row and rows per matrix.
- DATA_SIZE, 32, width of one result element.
- FIFO_DEPTH, 4, aligned-row buffer depth; must be >= MATRIX_SIZE, power of two.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous active-low reset.
- result_in  input  [DATA_SIZE-1:0] x MATRIX_SIZE (unpacked)  skewed column results from array `out_sum`.
- result_valid  input  1  column 0 of result_in holds a valid element this cycle; column j is valid j cycles later.
- output_ready  output  1  to frame: room for one full matrix (N rows) guaranteed.
- row_data  output  [DATA_SIZE-1:0] x MATRIX_SIZE (unpacked)  aligned row at FIFO head.
- row_valid  output  1  row_data valid.
- row_ready  input  1  consumer accepts row when row_valid && row_ready.
- row_last  output  1  row_data is row N-1 of its matrix.
- overflow  output  1  sticky: an aligned row was dropped because the FIFO was full.

Behaviour:
- Reset (reset==0 at an edge): all of the following clear, and every output reads 0 except `output_ready`, which is 1 after reset:
  - FIFO pointers and count, delay lines, row counter, overflow.
- Reset mid-stream discards in-flight and buffered rows; no partial row emerges afterwards.
- De-skew:
  - Column j delayed by N-1-j registers; column N-1 passes undelayed.
  - result_valid delayed by N-1 registers to form `push`.
  - For result_valid at cycle t, the aligned row is written at the end of cycle t+N-1.
  - row_valid is first visible in cycle t+N (latency N when the FIFO is empty).
- FIFO:
  - First-word-fall-through, registered storage; row_data is driven from the head entry.
  - pop = row_valid && row_ready.
  - push is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and pop occurs in the same cycle.
  - Otherwise the row is dropped and overflow is set (sticky until reset).
  - Pointers wrap modulo FIFO_DEPTH; count is unchanged on simultaneous push+pop.
  - Empty: row_valid=0 and row_data holds its last value; row_ready is ignored.
- output_ready:
  - Registered, updated every cycle: output_ready = (count + inflight) <= FIFO_DEPTH - N.
  - inflight = number of set bits in the valid delay line plus result_valid.
  - Deasserts one cycle after the condition fails; the frame tolerates this because the bound reserves N slots.
- row_last:
  - Row counter increments on each pop, wraps from N-1 to 0.
  - row_last = (row counter == N-1) && row_valid.
  - Dropped rows do not advance the counter.
- Back-to-back result_valid every cycle is supported, giving N rows per matrix on consecutive cycles.

Optional Feature:
- Macro: RESULT_COLLECTOR_STATS_EN.
- Defined: adds outputs matrices_out [15:0], incremented on pop with row_last, and rows_dropped [15:0], incremented per dropped row. Both saturate at 16'hFFFF, reset to 0, and are cleared by reset.
- Undefined: both ports exist but are tied to 0; no counter logic is synthesised.

Decomposition:
- Package systolic_pkg holds:
  - typedef result_row_t (unpacked DATA_SIZE x MATRIX_SIZE).
  - localparam functions clog2-based FIFO pointer width.
  - STAT_WIDTH=16.
- One sub-module is natural: row_fifo (parameterised FWFT FIFO with count output), instantiated once.
- De-skew delay lines stay inline in result_collector.

Test Plan (N=2, DATA_SIZE=32, FIFO_DEPTH=4):
- Latency: reset low 2 cycles, release; result_valid=1 at cycle 0 with col0=0x11; col1=0x22 at cycle 1 -> row_valid=1 at cycle 2 with row_data={0x11,0x22}, row_last=0, output_ready stays 1.
- Matrix stream: two rows (A,B) on consecutive cycles, row_ready=1 -> rows A,B on cycles 2,3; row_last=1 only on B; output_ready remains 1.
- Backpressure/full: row_ready=0, push 4 rows -> count=4, output_ready=0 from the cycle after inflight+count>2; row_valid held with row A.
- Full with simultaneous pop: FIFO full, row_ready=1 in the same cycle a 5th row arrives -> row accepted, overflow stays 0, output order A,B,C,D,E.
- Overflow: FIFO full, row_ready=0, push 5th row -> row dropped, overflow=1 and sticky; with STATS_EN, rows_dropped=1; drain yields exactly 4 rows.
- Reset mid-operation: reset low for 1 cycle while 2 rows are buffered and 1 is in flight -> next cycle row_valid=0, output_ready=1, overflow=0; no stale row ever appears.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types, sizing helpers and statistics width for the systolic array
// result path.
package systolic_pkg;

   localparam int DEF_MATRIX_SIZE = 2;
   localparam int DEF_DATA_SIZE   = 32;
   localparam int DEF_FIFO_DEPTH  = 4;
   localparam int STAT_WIDTH      = 16;

   typedef logic [DEF_DATA_SIZE-1:0] result_row_t [DEF_MATRIX_SIZE];

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
      return (v == {STAT_WIDTH{1'b1}}) ? v : v + STAT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/row_fifo.sv
// First-word-fall-through row buffer with registered storage and occupancy count.
// A write into a full buffer succeeds only when the head is popped in the same cycle.
module row_fifo
   import systolic_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop_ready,
   output logic [WIDTH-1:0]           head_data,
   output logic                       head_valid,
   output logic                       pop,
   output logic                       drop,
   output logic [ptr_width(DEPTH):0]  count
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic             accept;

   // Push/pop arbitration, pointer and occupancy update.
   always_comb begin
      head_valid = (count_q != CW'(0));
      pop        = head_valid && pop_ready;
      accept     = push && ((count_q < CW'(DEPTH)) || pop);
      drop       = push && !accept;
      mem_d      = mem_q;
      if (accept) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         last_d   = mem_q[rd_ptr_q];
      end else begin
         rd_ptr_d = rd_ptr_q;
         last_d   = last_q;
      end
      case ({accept, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset: while empty the output falls back to last_q.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= PW'(0);
         rd_ptr_q <= PW'(0);
         count_q  <= CW'(0);
         last_q   <= {WIDTH{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         last_q   <= last_d;
      end
   end

   assign head_data = head_valid ? mem_q[rd_ptr_q] : last_q;
   assign count     = count_q;

endmodule

// File: rtl/result_collector.sv
// De-skews staggered systolic result columns into aligned rows, buffers them and
// throttles the frame via output_ready. Optional counters: RESULT_COLLECTOR_STATS_EN.
module result_collector
   import systolic_pkg::*;
#(
   parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
   parameter int DATA_SIZE   = DEF_DATA_SIZE,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_SIZE-1:0]  result_in [MATRIX_SIZE],
   input  logic                  result_valid,
   output logic                  output_ready,
   output logic [DATA_SIZE-1:0]  row_data [MATRIX_SIZE],
   output logic                  row_valid,
   input  logic                  row_ready,
   output logic                  row_last,
   output logic                  overflow,
   output logic [STAT_WIDTH-1:0] matrices_out,
   output logic [STAT_WIDTH-1:0] rows_dropped
);

   localparam int N  = MATRIX_SIZE;
   localparam int VD = MATRIX_SIZE - 1;
   localparam int CW = ptr_width(FIFO_DEPTH) + 1;
   localparam int SW = CW + 1;
   localparam int RW = ptr_width(MATRIX_SIZE);

   logic [VD-1:0]          vld_q, vld_d;
   logic                   push;
   logic [N*DATA_SIZE-1:0] push_row;
   logic [N*DATA_SIZE-1:0] head_row;
   logic                   fifo_pop;
   logic                   fifo_drop;
   logic [CW-1:0]          fifo_count;
   logic [SW-1:0]          occupancy;
   logic                   output_ready_q, output_ready_d;
   logic                   overflow_q, overflow_d;
   logic [RW-1:0]          row_cnt_q, row_cnt_d;

   for (genvar j = 0; j < N; j++) begin : g_col
      localparam int D = N - 1 - j;
      if (D == 0) begin : g_pass
         assign push_row[j*DATA_SIZE +: DATA_SIZE] = result_in[j];
      end else begin : g_dly
         logic [DATA_SIZE-1:0] dly_q [D];
         logic [DATA_SIZE-1:0] dly_d [D];

         // Column j waits D cycles so it lines up with the last column.
         always_comb begin
            dly_d[0] = result_in[j];
            for (int k = 1; k < D; k++) begin
               dly_d[k] = dly_q[k-1];
            end
         end

         // Delay-line registers, cleared so no partial row survives reset.
         always_ff @(posedge clk) begin
            if (!reset) begin
               for (int k = 0; k < D; k++) begin
                  dly_q[k] <= {DATA_SIZE{1'b0}};
               end
            end else begin
               dly_q <= dly_d;
            end
         end

         assign push_row[j*DATA_SIZE +: DATA_SIZE] = dly_q[D-1];
      end
   end

   assign push = vld_q[VD-1];

   row_fifo #(
      .WIDTH (N*DATA_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_row_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_data  (push_row),
      .pop_ready  (row_ready),
      .head_data  (head_row),
      .head_valid (row_valid),
      .pop        (fifo_pop),
      .drop       (fifo_drop),
      .count      (fifo_count)
   );

   // Valid delay, admission control, sticky overflow and row position.
   always_comb begin
      vld_d     = (vld_q << 1) | VD'(result_valid);
      occupancy = SW'(fifo_count) + SW'(result_valid);
      for (int k = 0; k < VD; k++) begin
         occupancy = occupancy + SW'(vld_q[k]);
      end
      output_ready_d = (occupancy <= SW'(FIFO_DEPTH - N));
      overflow_d     = overflow_q | fifo_drop;
      if (fifo_pop) begin
         if (row_cnt_q == RW'(N - 1)) begin
            row_cnt_d = RW'(0);
         end else begin
            row_cnt_d = row_cnt_q + RW'(1);
         end
      end else begin
         row_cnt_d = row_cnt_q;
      end
   end

   // Control registers; output_ready comes out of reset asserted.
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_q          <= VD'(0);
         output_ready_q <= 1'b1;
         overflow_q     <= 1'b0;
         row_cnt_q      <= RW'(0);
      end else begin
         vld_q          <= vld_d;
         output_ready_q <= output_ready_d;
         overflow_q     <= overflow_d;
         row_cnt_q      <= row_cnt_d;
      end
   end

   // Unpack the head entry into per-column outputs.
   always_comb begin
      for (int j = 0; j < N; j++) begin
         row_data[j] = head_row[j*DATA_SIZE +: DATA_SIZE];
      end
   end

   assign row_last     = row_valid && (row_cnt_q == RW'(N - 1));
   assign output_ready = output_ready_q;
   assign overflow     = overflow_q;

`ifdef RESULT_COLLECTOR_STATS_EN
   logic [STAT_WIDTH-1:0] mat_cnt_q, mat_cnt_d;
   logic [STAT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

   // Saturating completed-matrix and dropped-row counters.
   always_comb begin
      if (fifo_pop && row_last) begin
         mat_cnt_d = sat_inc(mat_cnt_q);
      end else begin
         mat_cnt_d = mat_cnt_q;
      end
      if (fifo_drop) begin
         drop_cnt_d = sat_inc(drop_cnt_q);
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mat_cnt_q  <= {STAT_WIDTH{1'b0}};
         drop_cnt_q <= {STAT_WIDTH{1'b0}};
      end else begin
         mat_cnt_q  <= mat_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign matrices_out = mat_cnt_q;
   assign rows_dropped = drop_cnt_q;
`else
   assign matrices_out = {STAT_WIDTH{1'b0}};
   assign rows_dropped = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_result_collector.sv
// Randomized scoreboard bench for result_collector (N=2, 32-bit data, depth 4),
// with directed phases for latency, full, full-with-pop, overflow and mid-stream reset.
module tb_result_collector;

   localparam int N        = 2;
   localparam int DW       = 32;
   localparam int DEPTH    = 4;
   localparam int RAND_END = 1500;
   localparam int LAST     = 1530;
   localparam int MAXC     = 1600;

   typedef struct packed {
      logic          last;
      logic [N*DW-1:0] d;
   } row_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] result_in [N];
   logic          result_valid;
   logic          output_ready;
   logic [DW-1:0] row_data [N];
   logic          row_valid;
   logic          row_ready;
   logic          row_last;
   logic          overflow;
   logic [15:0]   matrices_out;
   logic [15:0]   rows_dropped;

   always #5 clk = ~clk;

   result_collector #(
      .MATRIX_SIZE (N),
      .DATA_SIZE   (DW),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .result_in    (result_in),
      .result_valid (result_valid),
      .output_ready (output_ready),
      .row_data     (row_data),
      .row_valid    (row_valid),
      .row_ready    (row_ready),
      .row_last     (row_last),
      .overflow     (overflow),
      .matrices_out (matrices_out),
      .rows_dropped (rows_dropped)
   );

   int checks = 0;
   int errors = 0;
   bit done   = 1'b0;

   row_t exp_q [$];
   row_t m_q [$];
   bit            hist_v [MAXC];
   logic [DW-1:0] hist_d [MAXC][N];
   int reset_cycle = -1;
   int accepted    = 0;
   int pv = 50;
   int pr = 50;

   // Model state after the upcoming edge, and the committed view of the current cycle.
   bit            m_ovf  = 1'b0;
   int            m_mat  = 0;
   int            m_drop = 0;
   logic [N*DW-1:0] m_hold = '0;
   int            m_cnt_n = 0, m_cnt_c = 0;
   bit            m_last_n = 1'b0, m_last_c = 1'b0;
   bit            m_ordy_n = 1'b1, m_ordy_c = 1'b1;
   bit            m_ovf_n = 1'b0, m_ovf_c = 1'b0;
   logic [N*DW-1:0] m_hold_n = '0, m_hold_c = '0;
   int            m_mat_n = 0, m_mat_c = 0;
   int            m_drop_n = 0, m_drop_c = 0;

   row_t            mon_e;
   logic [N*DW-1:0] mon_got;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic plan(input int c, output bit rl, output bit rv, output bit rdy);
      rl = 1'b0; rv = 1'b0; rdy = 1'b1;
      if (c < 2 || c == 49) begin
         rl = 1'b1;
      end else if (c < 12) begin
         rv = (c == 3) || (c == 8) || (c == 9);
      end else if (c < 30) begin
         rv  = (c >= 14 && c <= 17) || (c == 22) || (c == 26);
         rdy = (c == 23);
      end else if (c < 45) begin
         rdy = 1'b1;
      end else if (c < 52) begin
         rv  = (c == 45) || (c == 46) || (c == 48);
         rdy = 1'b0;
      end else if (c < RAND_END) begin
         if (c % 100 == 52) begin
            pv = int'($urandom_range(100, 20));
            pr = int'($urandom_range(100, 10));
         end
         rv  = int'($urandom_range(99, 0)) < pv;
         rdy = int'($urandom_range(99, 0)) < pr;
         rl  = ($urandom_range(399, 0) == 0);
      end
   endtask

   task automatic drive_cycle(input int c, input bit rl, input bit rv, input bit rdy);
      int   win;
      int   src;
      bit   pop_m;
      row_t r;
      for (int j = 0; j < N; j++) hist_d[c][j] = $urandom;
      hist_v[c]    = rv && !rl;
      reset        = !rl;
      result_valid = hist_v[c];
      row_ready    = rdy;
      for (int j = 0; j < N; j++) result_in[j] = (c - j >= 0) ? hist_d[c-j][j] : $urandom;
      if (rl) begin
         m_q.delete();
         exp_q.delete();
         reset_cycle = c;
         accepted = 0;
         m_ovf = 1'b0; m_mat = 0; m_drop = 0; m_hold = '0;
         m_ordy_n = 1'b1;
      end else begin
         win = 0;
         for (int k = c - N + 1; k <= c; k++) if (k > reset_cycle && hist_v[k]) win++;
         m_ordy_n = (m_q.size() + win) <= (DEPTH - N);
         pop_m = (m_q.size() > 0) && rdy;
         if (pop_m) begin
            r = m_q.pop_front();
            m_hold = r.d;
            if (r.last) m_mat++;
         end
         src = c - (N - 1);
         if (src > reset_cycle && hist_v[src]) begin
            if (m_q.size() < DEPTH) begin
               for (int j = 0; j < N; j++) r.d[j*DW +: DW] = hist_d[src][j];
               r.last = ((accepted % N) == N - 1);
               accepted++;
               m_q.push_back(r);
               exp_q.push_back(r);
            end else begin
               m_ovf = 1'b1;
               m_drop++;
            end
         end
      end
      m_cnt_n  = m_q.size();
      m_last_n = (m_q.size() > 0) ? m_q[0].last : 1'b0;
      m_ovf_n  = m_ovf;
      m_hold_n = m_hold;
      m_mat_n  = m_mat;
      m_drop_n = m_drop;
   endtask

   task automatic commit();
      m_cnt_c  = m_cnt_n;
      m_last_c = m_last_n;
      m_ordy_c = m_ordy_n;
      m_ovf_c  = m_ovf_n;
      m_hold_c = m_hold_n;
      m_mat_c  = m_mat_n;
      m_drop_c = m_drop_n;
   endtask

   // Monitor: compares status every cycle and retires scoreboard rows on each handshake.
   always @(negedge clk) begin
      if (!done) begin
         for (int j = 0; j < N; j++) mon_got[j*DW +: DW] = row_data[j];
         check("row_valid", 64'(row_valid), 64'(m_cnt_c != 0));
         check("row_last", 64'(row_last), 64'(m_last_c && (m_cnt_c != 0)));
         check("output_ready", 64'(output_ready), 64'(m_ordy_c));
         check("overflow", 64'(overflow), 64'(m_ovf_c));
`ifdef RESULT_COLLECTOR_STATS_EN
         check("matrices_out", 64'(matrices_out), 64'(m_mat_c));
         check("rows_dropped", 64'(rows_dropped), 64'(m_drop_c));
`else
         check("matrices_out", 64'(matrices_out), 64'(0));
         check("rows_dropped", 64'(rows_dropped), 64'(0));
`endif
         if (row_valid) begin
            if (reset && row_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL scoreboard: got row %0h expected no row", mon_got);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("row_data", mon_got, mon_e.d);
                  check("row_last_sb", 64'(row_last), 64'(mon_e.last));
               end
            end
         end else begin
            check("row_data_hold", mon_got, m_hold_c);
         end
      end
   end

   initial begin
      bit rl, rv, rdy;
      for (int c = 0; c < LAST; c++) begin
         plan(c, rl, rv, rdy);
         drive_cycle(c, rl, rv, rdy);
         @(posedge clk);
         #1;
         commit();
      end
      @(negedge clk);
      #1;
      done = 1'b1;
      check("drain_empty", 64'(exp_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
